// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : Fetch-stage program counter with reset vector, stall, relative
//            branch and optional call/return stack (macro PC_UNIT_RAS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int                ADDR_W      = 24,
    parameter int                OFF_W       = 12,
    parameter int                INC_STEP    = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int                STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              write,
    input  logic              PC_INC,
    input  logic              branch,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] ins_in,
    input  logic [OFF_W-1:0]  br_off,
    output logic [ADDR_W-1:0] ins_out,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err
);

    localparam logic [ADDR_W-1:0] c_inc = ADDR_W'(INC_STEP);

    logic [ADDR_W-1:0]       r_pc;
    logic [ADDR_W-1:0]       w_pc_inc;
    logic [ADDR_W-1:0]       w_pc_br;
    logic [ADDR_W-1:0]       w_br_ext;
    logic signed [OFF_W-1:0] w_off_s;

    // Signed cast so the size cast sign-extends the offset.
    assign w_off_s  = br_off;
    assign w_br_ext = ADDR_W'(w_off_s);
    assign w_pc_inc = r_pc + c_inc;
    assign w_pc_br  = r_pc + w_br_ext;
    assign ins_out  = r_pc;

`ifdef PC_UNIT_RAS_EN
    localparam int                 c_ptr_w = $clog2(STACK_DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(STACK_DEPTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;
    logic [c_ptr_w-1:0] w_wr_ptr;
    logic [c_ptr_w-1:0] w_top_ptr;
    logic               w_full;
    logic               w_empty;
    logic               w_push;

    assign w_full    = (r_cnt == c_depth);
    assign w_empty   = (r_cnt == '0);
    // Depth is a power of two, so the pointer wraps cleanly at full.
    assign w_wr_ptr  = r_cnt[c_ptr_w-1:0];
    assign w_top_ptr = w_wr_ptr - c_ptr_w'(1);
    assign w_push    = !reset && !stall && !write && call && !w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_wr_ptr] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= RESET_VEC;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (!stall) begin
            if (write) begin
                r_pc <= ins_in;
            end else if (call) begin
                r_pc <= ins_in;
                if (w_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_one;
                end
            end else if (ret) begin
                if (w_empty) begin
                    r_err <= 1'b1;
                end else begin
                    r_pc  <= r_stack[w_top_ptr];
                    r_cnt <= r_cnt - c_one;
                end
            end else if (branch) begin
                r_pc <= w_pc_br;
            end else if (PC_INC) begin
                r_pc <= w_pc_inc;
            end
        end
    end

    assign stk_full  = w_full;
    assign stk_empty = w_empty;
    assign stk_err   = r_err;
`else
    logic w_unused_ras;

    // Without the stack, call degenerates to a load and ret is transparent.
    assign w_unused_ras = ret | (STACK_DEPTH > 0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_VEC;
        end else if (!stall) begin
            if (write || call) begin
                r_pc <= ins_in;
            end else if (branch) begin
                r_pc <= w_pc_br;
            end else if (PC_INC) begin
                r_pc <= w_pc_inc;
            end
        end
    end

    assign stk_full  = 1'b0;
    assign stk_empty = 1'b1;
    assign stk_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Scoreboard bench for pc_unit; expected state queued per issued
//            command and compared by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
    localparam bit c_ras = 1'b1;
`else
    localparam bit c_ras = 1'b0;
`endif

    localparam logic [5:0] c_idle  = 6'b000000;
    localparam logic [5:0] c_stall = 6'b100000;
    localparam logic [5:0] c_wr    = 6'b010000;
    localparam logic [5:0] c_call  = 6'b001000;
    localparam logic [5:0] c_ret   = 6'b000100;
    localparam logic [5:0] c_br    = 6'b000010;
    localparam logic [5:0] c_inc   = 6'b000001;

    typedef struct {
        string       nm;
        logic [26:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, write, pc_inc, branch, call, ret;
    logic [23:0] ins_in;
    logic [11:0] br_off;
    logic [23:0] ins_out;
    logic        stk_full, stk_empty, stk_err;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    pc_unit #(
        .ADDR_W     (24),
        .OFF_W      (12),
        .INC_STEP   (1),
        .RESET_VEC  (24'h000010),
        .STACK_DEPTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .write    (write),
        .PC_INC   (pc_inc),
        .branch   (branch),
        .call     (call),
        .ret      (ret),
        .ins_in   (ins_in),
        .br_off   (br_off),
        .ins_out  (ins_out),
        .stk_full (stk_full),
        .stk_empty(stk_empty),
        .stk_err  (stk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [26:0] act, input logic [26:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pc=%h full=%b empty=%b err=%b, required pc=%h full=%b empty=%b err=%b",
                     nm, act[26:3], act[2], act[1], act[0], exp[26:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Expected values: pc/flags with the stack built, pc without it.
    task automatic stepr(input string nm, input logic [5:0] cmd, input logic [23:0] ins,
                         input logic [11:0] off, input logic [23:0] pc_ras, input logic [23:0] pc_no,
                         input logic f, input logic e, input logic er);
        exp_t x;
        @(negedge clk);
        {stall, write, call, ret, branch, pc_inc} = cmd;
        ins_in = ins;
        br_off = off;
        x.nm = nm;
        x.v  = c_ras ? {pc_ras, f, e, er} : {pc_no, 1'b0, 1'b1, 1'b0};
        q.push_back(x);
    endtask

    task automatic step(input string nm, input logic [5:0] cmd, input logic [23:0] ins,
                        input logic [11:0] off, input logic [23:0] pc,
                        input logic f, input logic e, input logic er);
        stepr(nm, cmd, ins, off, pc, pc, f, e, er);
    endtask

    task automatic drain();
        @(negedge clk);
        {stall, write, call, ret, branch, pc_inc} = c_idle;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations pending, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                check(mon_e.nm, {ins_out, stk_full, stk_empty, stk_err}, mon_e.v);
            end
        end
    end

    initial begin
        reset = 1'b1;
        {stall, write, call, ret, branch, pc_inc} = c_idle;
        ins_in = '0;
        br_off = '0;
        @(posedge clk);
        #1;
        check("reset_hold", {ins_out, stk_full, stk_empty, stk_err}, {24'h000010, 3'b010});
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_release", {ins_out, stk_full, stk_empty, stk_err}, {24'h000010, 3'b010});

        step("write_100", c_wr,  24'd100, 12'h0, 24'd100, 0, 1, 0);
        step("inc_1",     c_inc, 24'h0,   12'h0, 24'd101, 0, 1, 0);
        step("inc_2",     c_inc, 24'h0,   12'h0, 24'd102, 0, 1, 0);
        step("inc_3",     c_inc, 24'h0,   12'h0, 24'd103, 0, 1, 0);
        step("write_max", c_wr,  24'hFFFFFF, 12'h0, 24'hFFFFFF, 0, 1, 0);
        step("inc_wrap",  c_inc, 24'h0, 12'h0,   24'h000000, 0, 1, 0);
        step("br_m4",     c_br,  24'h0, 12'hFFC, 24'hFFFFFC, 0, 1, 0);
        step("br_p8",     c_br,  24'h0, 12'h008, 24'h000004, 0, 1, 0);
        step("write_200", c_wr,  24'h000200, 12'h0, 24'h000200, 0, 1, 0);
        step("call_1000", c_call, 24'h001000, 12'h0, 24'h001000, 0, 0, 0);
        stepr("ret_inc",  c_ret | c_inc, 24'h0, 12'h0, 24'h000201, 24'h001001, 0, 1, 0);

        step("write_300", c_wr,   24'h000300, 12'h0, 24'h000300, 0, 1, 0);
        step("call_400",  c_call, 24'h000400, 12'h0, 24'h000400, 0, 0, 0);
        step("call_500",  c_call, 24'h000500, 12'h0, 24'h000500, 0, 0, 0);
        step("call_600",  c_call, 24'h000600, 12'h0, 24'h000600, 0, 0, 0);
        stepr("ret_a",    c_ret, 24'h0, 12'h0, 24'h000501, 24'h000600, 0, 0, 0);
        stepr("ret_b",    c_ret, 24'h0, 12'h0, 24'h000401, 24'h000600, 0, 0, 0);
        stepr("ret_c",    c_ret, 24'h0, 12'h0, 24'h000301, 24'h000600, 0, 1, 0);

        step("prio_wr_call_inc", c_wr | c_call | c_inc, 24'h000777, 12'h0, 24'h000777, 0, 1, 0);
        step("stall_call", c_stall | c_call, 24'h000999, 12'h0, 24'h000777, 0, 1, 0);
        step("call_800",   c_call, 24'h000800, 12'h0, 24'h000800, 0, 0, 0);
        step("stall_ret",  c_stall | c_ret, 24'h0, 12'h0, 24'h000800, 0, 0, 0);
        stepr("ret_778",   c_ret, 24'h0, 12'h0, 24'h000778, 24'h000800, 0, 1, 0);

        step("write_0", c_wr, 24'h000000, 12'h0, 24'h000000, 0, 1, 0);
        for (int k = 1; k <= 9; k++) begin
            step($sformatf("ovf_call_%0d", k), c_call, 24'(k * 256), 12'h0, 24'(k * 256),
                 (k >= 8), 0, (k == 9));
        end
        for (int k = 1; k <= 8; k++) begin
            stepr($sformatf("ovf_ret_%0d", k), c_ret, 24'h0, 12'h0, 24'((8 - k) * 256 + 1),
                  24'h000900, 0, (k == 8), 1);
        end
        stepr("udf_ret", c_ret, 24'h0, 12'h0, 24'h000001, 24'h000900, 0, 1, 1);

        step("pre_rst_a", c_call, 24'h000A00, 12'h0, 24'h000A00, 0, 0, 1);
        step("pre_rst_b", c_call, 24'h000B00, 12'h0, 24'h000B00, 0, 0, 1);
        step("pre_rst_c", c_call, 24'h000C00, 12'h0, 24'h000C00, 0, 0, 1);
        drain();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", {ins_out, stk_full, stk_empty, stk_err}, {24'h000010, 3'b010});
        @(negedge clk);
        reset = 1'b0;

        step("post_rst_inc", c_inc, 24'h0, 12'h0, 24'h000011, 0, 1, 0);
        stepr("ret_br", c_ret | c_br, 24'h0, 12'h004, 24'h000011, 24'h000015, 0, 1, 1);
        step("call_20", c_call, 24'h000020, 12'h0, 24'h000020, 0, 0, 1);
        stepr("ret_20", c_ret, 24'h0, 12'h0, 24'h000012, 24'h000020, 0, 1, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the processor fetch stage, replacing the fixed 24-bit load/increment PC. Adds reset vector, stall, PC-relative branch, and a call/return address stack. Sits between the control unit (which drives the command strobes) and instruction memory (addressed by `ins_out`).

## Interface

Parameters:
- `ADDR_W`, 24, PC / address width in bits
- `OFF_W`, 12, branch offset width (two's complement)
- `INC_STEP`, 1, increment applied by `PC_INC` and stored as the call return address
- `RESET_VEC`, 0, PC value loaded on reset
- `STACK_DEPTH`, 8, return-address stack entries (power of two, ≥2)

Ports:
- `clk` input 1: clock; all state updates on the rising edge
- `reset` input 1: asynchronous, active-high reset
- `stall` input 1: freezes the PC and stack when high
- `write` input 1: absolute load of `ins_in`
- `PC_INC` input 1: increment by `INC_STEP`
- `branch` input 1: relative jump by `br_off`
- `call` input 1: push return address, then jump to `ins_in`
- `ret` input 1: pop the stack into the PC
- `ins_in` input ADDR_W: absolute target for `write` / `call`
- `br_off` input OFF_W: signed branch offset
- `ins_out` output ADDR_W: current PC (registered)
- `stk_full` output 1: stack holds STACK_DEPTH entries
- `stk_empty` output 1: stack holds 0 entries
- `stk_err` output 1: sticky overflow/underflow flag

## Operation

- Exactly one action per cycle. Priority, highest first: `reset` > `stall` > `write` > `call` > `ret` > `branch` > `PC_INC` > hold. Lower-priority strobes asserted in the same cycle are ignored, not queued.
- **write**: PC <= `ins_in`. Stack untouched.
- **call**: push (PC + INC_STEP) mod 2^ADDR_W, then PC <= `ins_in`.
  - When full, the push is dropped, the PC still loads `ins_in`, and `stk_err` is set.
- **ret**: PC <= top entry, then pop.
  - When empty, the PC holds, the count stays 0, and `stk_err` is set.
- **branch**: PC <= (PC + sign-extend(`br_off`)) mod 2^ADDR_W.
- **PC_INC**: PC <= (PC + INC_STEP) mod 2^ADDR_W. Wraps from all-ones to INC_STEP−1.
- **Arithmetic**: all of it is ADDR_W bits, unsigned wrap; no overflow indication.
- **Stack**: LIFO with a count register 0..STACK_DEPTH.
  - `stk_full` = (count == STACK_DEPTH).
  - `stk_empty` = (count == 0).
  - Both are decoded from registered count only, so they are glitch-free relative to the inputs.
- **stk_err**: once set, it remains set until `reset`.
- **stall**: overrides every strobe. No PC change, no push/pop, no `stk_err` update.

## Timing

- **Reset**: `reset` high asynchronously forces:
  - `ins_out` = RESET_VEC, count = 0, `stk_err` = 0
  - `stk_empty` = 1, `stk_full` = 0
  - Stack contents are don't-care.
  - The first action is taken at the first rising edge after `reset` deasserts.
- **Reset mid-operation**: a call or ret in flight is abandoned. No partial push survives.
- **Latency**: one cycle. A strobe sampled at edge N shows its effect on `ins_out` and the flags immediately after edge N. There are no combinational paths from inputs to outputs.
- **Back-to-back**: call/ret on consecutive cycles is supported. A ret in the cycle after a call returns exactly the address pushed by that call.
- **Throughput**: one action per clock, no bubbles.

## Configuration

- Macro `PC_UNIT_RAS_EN` controls the return-address stack.
- **Defined**: the return-address stack is built as described above.
- **Undefined**:
  - No stack storage is generated.
  - `call` behaves exactly as `write` (PC <= `ins_in`, no push).
  - `ret` is ignored and treated as hold, with lower-priority strobes still evaluated.
  - `stk_full` = 0, `stk_empty` = 1, `stk_err` = 0 constantly.
  - Priority order is otherwise unchanged.

## Test plan

- **Reset/load/increment**: RESET_VEC=0x000010, `reset` pulse → `ins_out`=0x000010. Then `write`, `ins_in`=100 → 100. Then 3 cycles `PC_INC` → 101, 102, 103.
- **Wrap and branch**: `write` 0xFFFFFF, `PC_INC` → 0x000000. Then `branch` `br_off`=−4 (0xFFC) → 0xFFFFFC. Then `branch` +8 → 0x000004.
- **Call/return**: PC=0x000200, `call` `ins_in`=0x001000 → PC 0x001000, `stk_empty`=0. Then `ret` → 0x000201, `stk_empty`=1. Nested 3 calls then 3 rets return in LIFO order.
- **Overflow/underflow**: 9 calls with STACK_DEPTH=8 → `stk_full`=1 after the 8th, `stk_err`=1 after the 9th, PC = 9th target. Then 8 rets succeed, and a 9th ret holds PC with `stk_err` still 1.
- **Priority and stall**: `write`+`call`+`PC_INC` together → only the load, no push. `stall` with `call` asserted → PC and count unchanged.
- **Async reset mid-run**: assert `reset` between edges with count=3 → `ins_out`=RESET_VEC and `stk_empty`=1 before the next edge. With `PC_UNIT_RAS_EN` undefined, `call` acts as a load and `ret` as hold.
